// File: rtl/alu.sv
// alu: 16-bit registered ALU with carry/less/overflow/zero/negative flags.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  aluControl,
  output logic [15:0] result,
  output logic        C,
  output logic        L,
  output logic        F,
  output logic        Z,
  output logic        N
);
  logic [16:0] sum, diff;
  logic [15:0] op_res;
  logic        upd, is_add, is_sub, is_cmp, add_ov, sub_ov, lt_s;
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign add_ov = (a[15] == b[15]) & (sum[15] != a[15]);
  assign sub_ov = (a[15] != b[15]) & (diff[15] != a[15]);
  assign lt_s   = $signed(a) < $signed(b);
  assign is_add = aluControl == 4'b1000;
  assign is_cmp = aluControl == 4'b0010;
  assign is_sub = is_cmp | (aluControl == 4'b0001);
  // NOP and reserved codes leave upd low so every output holds.
  always_comb begin
    op_res = 16'h0000;
    upd = 1'b1;
    case (aluControl)
      4'b1000: op_res = sum[15:0];
      4'b0001, 4'b0010: op_res = diff[15:0];
      4'b0011: op_res = a & b;
      4'b0100: op_res = a | b;
      4'b0101: op_res = a ^ b;
      4'b0110: op_res = b;
      4'b0111: op_res = b[4] ? a >> b[3:0] : a << b[3:0];
      4'b1001: op_res = $signed(a) >>> b[3:0];
      4'b1010: op_res = ~a;
      default: upd = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= 16'h0000;
      {C, L, F, Z, N} <= 5'b0;
    end else if (upd) begin
      result <= is_cmp ? result : op_res;
      C <= is_add ? sum[16] : is_sub & diff[16];
      L <= is_sub & diff[16];
      F <= is_add ? add_ov : is_sub & sub_ov;
      Z <= is_sub ? a == b : op_res == 16'h0000;
      N <= is_sub ? lt_s : op_res[15];
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for alu.
module tb_alu;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic [3:0]  aluControl = 4'h0;
  logic [15:0] result;
  logic        C, L, F, Z, N;
  int checks = 0, errors = 0;
  localparam logic [3:0] NOP = 4'b0000, SUB = 4'b0001, CMP = 4'b0010, AND = 4'b0011,
    OR = 4'b0100, XOR = 4'b0101, MOV = 4'b0110, LSH = 4'b0111, ADD = 4'b1000,
    ASHR = 4'b1001, NOT = 4'b1010, RSV = 4'b1111;
  alu dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .aluControl(aluControl),
    .result(result), .C(C), .L(L), .F(F), .Z(Z), .N(N)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got result=%h CLFZN=%b, expected result=%h CLFZN=%b",
               tag, got[20:5], got[4:0], exp[20:5], exp[4:0]);
    end
  endtask
  // Expected word is {result, C, L, F, Z, N}.
  task automatic step(input string tag, input logic r, input logic [3:0] ctl,
                      input logic [15:0] x, input logic [15:0] y, input logic [20:0] exp);
    @(negedge clk);
    reset = r; aluControl = ctl; a = x; b = y;
    @(posedge clk);
    #1;
    check(tag, {result, C, L, F, Z, N}, exp);
  endtask
  initial begin
    step("reset",     1'b1, ADD,  16'h0003, 16'h0001, {16'h0000, 5'b00000});
    step("add_3_1",   1'b0, ADD,  16'h0003, 16'h0001, {16'h0004, 5'b00000});
    step("add_carry", 1'b0, ADD,  16'hFFFF, 16'h0001, {16'h0000, 5'b10010});
    step("add_ovf",   1'b0, ADD,  16'h7FFF, 16'h0001, {16'h8000, 5'b00101});
    step("sub_3_1",   1'b0, SUB,  16'h0003, 16'h0001, {16'h0002, 5'b00000});
    step("sub_2_3",   1'b0, SUB,  16'h0002, 16'h0003, {16'hFFFF, 5'b11001});
    step("cmp_eq",    1'b0, CMP,  16'h0003, 16'h0003, {16'hFFFF, 5'b00010});
    step("cmp_lt",    1'b0, CMP,  16'h0002, 16'h0003, {16'hFFFF, 5'b11001});
    step("cmp_gt",    1'b0, CMP,  16'h0003, 16'h0002, {16'hFFFF, 5'b00000});
    step("cmp_sgn",   1'b0, CMP,  16'h8000, 16'h0001, {16'hFFFF, 5'b00101});
    step("and",       1'b0, AND,  16'h0002, 16'h0003, {16'h0002, 5'b00000});
    step("or",        1'b0, OR,   16'h0002, 16'h0003, {16'h0003, 5'b00000});
    step("xor",       1'b0, XOR,  16'h0002, 16'h0003, {16'h0001, 5'b00000});
    step("mov",       1'b0, MOV,  16'h0002, 16'h0003, {16'h0003, 5'b00000});
    step("not",       1'b0, NOT,  16'h0000, 16'h0003, {16'hFFFF, 5'b00001});
    step("and_zero",  1'b0, AND,  16'h00F0, 16'h0F00, {16'h0000, 5'b00010});
    step("lsh_left",  1'b0, LSH,  16'h0001, 16'h0004, {16'h0010, 5'b00000});
    step("lsh_right", 1'b0, LSH,  16'h8000, 16'h0011, {16'h4000, 5'b00000});
    step("lsh_zero",  1'b0, LSH,  16'h1234, 16'hFFE0, {16'h1234, 5'b00000});
    step("ashr",      1'b0, ASHR, 16'h8000, 16'h0004, {16'hF800, 5'b00001});
    step("ashr_hi_b", 1'b0, ASHR, 16'h8000, 16'hFFE1, {16'hC000, 5'b00001});
    step("add_pre",   1'b0, ADD,  16'hFFFF, 16'h0001, {16'h0000, 5'b10010});
    step("nop_hold",  1'b0, NOP,  16'h1234, 16'h5678, {16'h0000, 5'b10010});
    step("rsv_hold",  1'b0, RSV,  16'h7FFF, 16'h0001, {16'h0000, 5'b10010});
    step("add_set",   1'b0, ADD,  16'h7FFF, 16'h0001, {16'h8000, 5'b00101});
    step("mid_reset", 1'b1, ADD,  16'h7FFF, 16'h0001, {16'h0000, 5'b00000});
    step("post_rst",  1'b0, SUB,  16'h0002, 16'h0003, {16'hFFFF, 5'b11001});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 a  input  16  first operand; destination-register value.
REQ-005 b  input  16  second operand; source register or immediate value.
REQ-006 aluControl  input  4  operation select.
REQ-007 result  output  16  registered operation result.
REQ-008 C  output  1  registered carry/borrow flag.
REQ-009 L  output  1  registered unsigned-less-than flag.
REQ-010 F  output  1  registered signed-overflow flag.
REQ-011 Z  output  1  registered zero/equal flag.
REQ-012 N  output  1  registered signed-negative/signed-less flag.

Function
REQ-013 The block SHALL sample a, b and aluControl on each rising clk edge and present result and flags after that edge (1-cycle latency); there is no handshake.
REQ-014 The block SHALL decode aluControl as follows:
- 1000 ADD: a+b
- 0001 SUB: a-b
- 0010 CMP: a-b, flags only
- 0011 AND: a&b
- 0100 OR: a|b
- 0101 XOR: a^b
- 0110 MOV: b
- 0111 LSH: a<<b[3:0] if b[4]=0, else a>>b[3:0] (logical)
- 1001 ASHR: a>>>b[3:0] (arithmetic)
- 1010 NOT: ~a
- 0000 NOP
- 1011-1111 reserved
REQ-015 All arithmetic SHALL be modulo 2^16; the result is the low 16 bits.
REQ-016 For ADD, the block SHALL set C = carry-out of bit 15 and F = 1 when a and b have the same sign and the result sign differs; Z = (result==0); N = result[15]; L = 0.
REQ-017 For SUB and CMP, the block SHALL set C = 1 when a<b unsigned (borrow), L = (a<b unsigned), N = (a<b signed), Z = (a==b), and F = 1 when a and b differ in sign and the sign of a-b differs from the sign of a.
REQ-018 CMP SHALL update all five flags and SHALL leave result unchanged.
REQ-019 For AND, OR, XOR, MOV, LSH, ASHR and NOT, the block SHALL set Z = (result==0) and N = result[15], and force C = L = F = 0.
REQ-020 For shifts, shift amount 0 SHALL pass a unchanged; b bits above [4] SHALL be ignored.
REQ-021 NOP and reserved codes SHALL hold result and all flags at their previous values.
REQ-022 Operand or control changes between edges SHALL NOT affect outputs until the next rising edge.

Reset
REQ-023 When reset=1 at a rising edge, result SHALL become 16'h0000 and C, L, F, Z, N SHALL become 0, regardless of aluControl.
REQ-024 Reset SHALL take priority over any operation in the same cycle; the first operation after reset deasserts updates outputs one edge later.
REQ-025 Reset asserted mid-sequence SHALL discard the in-flight operation; no partial update is permitted.

Verification
REQ-026 ADD a=0003, b=0001 -> result=0004, C=0, F=0, Z=0, N=0 one cycle later; ADD a=FFFF, b=0001 -> result=0000, C=1, Z=1; ADD a=7FFF, b=0001 -> result=8000, F=1, N=1.
REQ-027 SUB a=0003, b=0001 -> result=0002, L=0, C=0; SUB a=0002, b=0003 -> result=FFFF, C=1, L=1, N=1.
REQ-028 CMP a=0003, b=0003 -> Z=1, L=0; CMP a=0002, b=0003 -> L=1, Z=0; CMP a=0003, b=0002 -> L=0, Z=0; CMP a=8000, b=0001 -> L=0, N=1; result unchanged in all four cases.
REQ-029 With a=0002, b=0003: AND -> 0002; OR -> 0003; XOR -> 0001; MOV -> 0003; NOT a=0000 -> FFFF, N=1.
REQ-030 Shifts: LSH a=0001, b=0004 -> 0010; LSH a=8000, b=0011 -> 4000; ASHR a=8000, b=0004 -> F800, N=1.
REQ-031 Hold and reset: a NOP or code 1111 after an ADD holds the prior result and flags; reset=1 -> result=0000 and all flags 0 at the next edge even with ADD selected.
